alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit registered ALU. Two requesters submit an operation: two operands plus a 4-bit op code. The block grants one requester at a time, round-robin, and drives the ALU inputs. It accounts for the ALU's one-cycle registered latency and returns the result with a one-cycle acknowledge. It sits between the ALU and its clients, for example the processor core and a peripheral/DMA engine.

## Interface
Parameters:
- none

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- REQ_0 / REQ_1  input  1  operation request from requester 0 / 1
- A_0, B_0 / A_1, B_1  input  8  operands; stable while the matching REQ is high
- OP_0 / OP_1  input  4  ALU op code; stable while the matching REQ is high
- ACK_0 / ACK_1  output  1  one-cycle pulse; RESULT is valid in the same cycle
- RESULT_0 / RESULT_1  output  8  result register per requester; holds its value until the next ACK to that requester
- ALU_IN_A, ALU_IN_B  output  8  registered operands to the ALU
- ALU_OP  output  4  registered op code to the ALU
- ALU_RESULT  input  8  ALU registered output
- BUSY  output  1  high in states ISSUE and CAPTURE
- GNT_ID  output  1  requester currently or last served

## Operation
State machine: IDLE, ISSUE, CAPTURE.
- **IDLE**
  - A requester is eligible when its REQ is high and its ACK is low in that cycle. A requester's REQ in its own ACK cycle is ignored.
  - No eligible requester: stay in IDLE.
  - One eligible requester: grant it.
  - Both eligible: grant the requester not equal to the last-served pointer.
  - On grant: load ALU_IN_A, ALU_IN_B and ALU_OP from the winner, set GNT_ID to the winner, update the pointer, go to ISSUE.
- **ISSUE**
  - ALU inputs are stable; the ALU registers its result at the closing edge.
  - Go to CAPTURE unconditionally.
- **CAPTURE**
  - ALU_RESULT is valid.
  - At the closing edge: RESULT_GNT_ID <= ALU_RESULT and ACK_GNT_ID <= 1, go to IDLE.
  - The other requester's RESULT is unchanged.
- ACK is high for exactly one cycle and is cleared at the next edge.
- The requester drops REQ on the cycle after ACK or keeps it high to request again. A re-request competes normally one cycle later.
- Arithmetic, width handling and truncation are entirely the ALU's. The block passes the 8-bit result through unmodified, for example a multiply keeps the low 8 bits.
- REQ deasserted mid-operation: the operation still completes and ACKs. Requesters must not do this.
- ALU_IN_A, ALU_IN_B and ALU_OP hold their values outside ISSUE and change only on a grant.

## Timing
- Reset values: state IDLE, ACK_0 = ACK_1 = 0, RESULT_0 = RESULT_1 = 8'h00, ALU_IN_A = ALU_IN_B = 8'h00, ALU_OP = 4'h0, BUSY = 0, GNT_ID = 0.
- The last-served pointer resets to 1, so requester 0 wins the first simultaneous request.
- Latency:
  - REQ sampled high in IDLE at edge N gives ISSUE after N and CAPTURE after N+1.
  - ACK and RESULT are valid in the cycle after edge N+2.
- Throughput: one operation per 3 cycles. With both REQs held continuously, ACKs alternate 0, 1, 0, 1 spaced 3 cycles apart.
- Reset mid-operation (any state):
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - The in-flight operation is discarded and never ACKed.
  - A held REQ is serviced after release.
- The ALU's own synchronous RESET is tied to the same net. ALU_RESULT is not used during reset.

## Configuration
- Macro ALU_ARB_COUNT_EN defined:
  - Adds outputs OP_COUNT_0 and OP_COUNT_1, 16 bits each.
  - Each counts ACKs to its requester and wraps 16'hFFFF to 16'h0000.
  - Both counters reset asynchronously to 0.
- Macro undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- **Single request:** REQ_0 with A_0 = 8'h05, B_0 = 8'h03, OP_0 = 4'h0 -> ACK_0 pulses exactly 3 edges later, RESULT_0 = 8'h08, ACK_1 stays 0, BUSY high for 2 cycles.
- **Simultaneous requests after reset:** REQ_0 with 8'h10 + 8'h20 (op 0) and REQ_1 with 8'h10 - 8'h20 (op 1) -> ACK_0 first with RESULT_0 = 8'h30; ACK_1 3 cycles later with RESULT_1 = 8'hF0.
- **Both REQs held for 12 cycles:** ACK sequence 0, 1, 0, 1 at 3-cycle spacing; no back-to-back grant to the same requester; RESULT of the idle requester stays unchanged.
- **ALU pass-through:**
  - Op 2, 8'h10 * 8'h10 -> 8'h00.
  - Op A, 8'h80 > 8'h7F -> 8'h01.
  - Op 4'hF, A = 8'h5A -> 8'h5A.
- **Reset during CAPTURE:** all outputs go to reset values immediately; no ACK after release. REQ_1 held through reset -> serviced and ACKed 3 edges after the first post-reset edge.
- **ALU_ARB_COUNT_EN defined:**
  - 5 operations on requester 1 -> OP_COUNT_1 = 5 and OP_COUNT_0 = 0.
  - OP_COUNT_0 forced to 16'hFFFF, then one ACK_0 -> 16'h0000.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of a shared 8-bit registered ALU (one op per 3 cycles).
// Optional per-requester ACK counters are enabled by defining ALU_ARB_COUNT_EN.
module alu_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_0,
  input  logic       REQ_1,
  input  logic [7:0] A_0,
  input  logic [7:0] B_0,
  input  logic [7:0] A_1,
  input  logic [7:0] B_1,
  input  logic [3:0] OP_0,
  input  logic [3:0] OP_1,
  output logic       ACK_0,
  output logic       ACK_1,
  output logic [7:0] RESULT_0,
  output logic [7:0] RESULT_1,
  output logic [7:0] ALU_IN_A,
  output logic [7:0] ALU_IN_B,
  output logic [3:0] ALU_OP,
  input  logic [7:0] ALU_RESULT,
  output logic       BUSY,
`ifdef ALU_ARB_COUNT_EN
  output logic [15:0] OP_COUNT_0,
  output logic [15:0] OP_COUNT_1,
`endif
  output logic       GNT_ID
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state_reg, state_next;
  logic   last_reg;
  logic   elig_0, elig_1, grant, winner;

  // A requester's REQ is ignored during its own ACK cycle.
  assign elig_0 = REQ_0 & ~ACK_0;
  assign elig_1 = REQ_1 & ~ACK_1;
  assign grant  = (state_reg == IDLE) & (elig_0 | elig_1);
  assign winner = (elig_0 & elig_1) ? ~last_reg : elig_1;
  assign BUSY   = (state_reg != IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ACK_0    <= 1'b0;
      ACK_1    <= 1'b0;
      RESULT_0 <= 8'h00;
      RESULT_1 <= 8'h00;
      ALU_IN_A <= 8'h00;
      ALU_IN_B <= 8'h00;
      ALU_OP   <= 4'h0;
      GNT_ID   <= 1'b0;
      last_reg <= 1'b1;
    end else begin
      ACK_0 <= 1'b0;
      ACK_1 <= 1'b0;
      if (grant) begin
        ALU_IN_A <= winner ? A_1  : A_0;
        ALU_IN_B <= winner ? B_1  : B_0;
        ALU_OP   <= winner ? OP_1 : OP_0;
        GNT_ID   <= winner;
        last_reg <= winner;
      end
      // ALU output registered at the end of ISSUE is valid throughout CAPTURE.
      if (state_reg == CAPTURE) begin
        if (GNT_ID) begin
          RESULT_1 <= ALU_RESULT;
          ACK_1    <= 1'b1;
        end else begin
          RESULT_0 <= ALU_RESULT;
          ACK_0    <= 1'b1;
        end
      end
    end
  end

`ifdef ALU_ARB_COUNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OP_COUNT_0 <= 16'h0000;
      OP_COUNT_1 <= 16'h0000;
    end else if (state_reg == CAPTURE) begin
      if (GNT_ID) OP_COUNT_1 <= OP_COUNT_1 + 16'h0001;
      else        OP_COUNT_0 <= OP_COUNT_0 + 16'h0001;
    end
  end
`endif

endmodule
